// File: rtl/intc_mmio.sv
// intc_mmio: memory-mapped, fixed-priority interrupt controller for the
// jacaranda CPU data-memory port. Rising edges on src_i latch into PEND,
// the lowest-index eligible source is presented to the CPU, and further
// requests are blocked until the handler writes STAT (EOI).
// Optional: define INTC_EVT_CNT_EN to add per-source 8-bit saturating
// edge counters CNT[i] at offsets 4+NUM_SRC+i.
module intc_mmio #(
  parameter int         NUM_SRC   = 4,
  parameter logic [7:0] BASE_ADDR = 8'd232
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [7:0]         addr_i,
  input  logic [7:0]         wdata_i,
  input  logic               we_i,
  output logic [7:0]         rdata_o,
  output logic               hit_o,
  output logic               int_req_o,
  output logic [7:0]         int_vec_o,
  input  logic               int_ack_i,
  output logic               int_en_o
);

`ifdef INTC_EVT_CNT_EN
  localparam int WIN = 4 + 2 * NUM_SRC;
`else
  localparam int WIN = 4 + NUM_SRC;
`endif
  localparam logic [8:0] WIN9 = 9'(WIN);

  typedef enum logic [1:0] {IDLE, REQ, SVC} state_e;

  state_e                    state_q, state_d;
  logic                      gie_q, gie_d;
  logic [NUM_SRC-1:0]        mask_q, mask_d;
  logic [NUM_SRC-1:0]        pend_q, pend_d;
  logic [NUM_SRC-1:0]        src_dly_q;
  logic [NUM_SRC-1:0][7:0]   vec_q, vec_d;
  logic [2:0]                id_q, id_d;
  logic                      req_q, req_d;
  logic [7:0]                ivec_q, ivec_d;
  logic                      en_q, en_d;

  logic [7:0]                off;
  logic                      wr_hit, busy, eoi, ack_take, id_live;
  logic [NUM_SRC-1:0]        rise, elig, id_oh;
  logic [2:0]                win;
  logic [7:0]                win_vec;

  assign off      = addr_i - BASE_ADDR;
  assign hit_o    = (addr_i >= BASE_ADDR) && ({1'b0, off} < WIN9);
  assign wr_hit   = we_i & hit_o;
  assign rise     = src_i & ~src_dly_q;
  assign elig     = pend_q & mask_q & {NUM_SRC{gie_q}};
  assign busy     = (state_q == SVC);
  assign eoi      = wr_hit && (off == 8'd3) && busy;
  assign ack_take = (state_q == REQ) && int_ack_i;
  assign id_live  = |(id_oh & elig);

  assign int_req_o = req_q;
  assign int_vec_o = ivec_q;
  assign int_en_o  = en_q;

  // Priority pick (lowest index wins) and one-hot decode of the latched id.
  always_comb begin
    win     = '0;
    win_vec = '0;
    id_oh   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win     = 3'(i);
        win_vec = vec_q[i];
      end
    end
    for (int i = 0; i < NUM_SRC; i++) id_oh[i] = (id_q == 3'(i));
  end

  // Register-file writes and pending-bit update; a new edge beats any clear.
  always_comb begin
    gie_d  = gie_q;
    mask_d = mask_q;
    vec_d  = vec_q;
    pend_d = pend_q;
    if (wr_hit && off == 8'd0) gie_d  = wdata_i[0];
    if (wr_hit && off == 8'd1) mask_d = wdata_i[NUM_SRC-1:0];
    for (int i = 0; i < NUM_SRC; i++)
      if (wr_hit && off == 8'(4 + i)) vec_d[i] = wdata_i;
    if (wr_hit && off == 8'd2) pend_d = pend_d & ~wdata_i[NUM_SRC-1:0];
    if (ack_take)              pend_d = pend_d & ~id_oh;
    pend_d = pend_d | rise;
  end

  // Request FSM: arbitrate in IDLE, hold in REQ, block in SVC until EOI.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    req_d   = req_q;
    ivec_d  = ivec_q;
    unique case (state_q)
      IDLE: begin
        req_d = 1'b0;
        if (|elig) begin
          id_d    = win;
          ivec_d  = win_vec;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (int_ack_i) begin
          req_d   = 1'b0;
          state_d = SVC;
        end else if (!id_live) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      SVC: begin
        req_d = 1'b0;
        if (eoi) state_d = IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
    en_d = gie_d && (state_d != SVC);
  end

  // State and register storage.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= IDLE;
      gie_q     <= 1'b0;
      mask_q    <= '0;
      pend_q    <= '0;
      src_dly_q <= '0;
      vec_q     <= '0;
      id_q      <= '0;
      req_q     <= 1'b0;
      ivec_q    <= '0;
      en_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      gie_q     <= gie_d;
      mask_q    <= mask_d;
      pend_q    <= pend_d;
      src_dly_q <= src_i;
      vec_q     <= vec_d;
      id_q      <= id_d;
      req_q     <= req_d;
      ivec_q    <= ivec_d;
      en_q      <= en_d;
    end
  end

`ifdef INTC_EVT_CNT_EN
  logic [NUM_SRC-1:0][7:0] cnt_q, cnt_d;

  // Saturating edge counters; a write clears, an edge in the same cycle counts.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (wr_hit && off == 8'(4 + NUM_SRC + i)) cnt_d[i] = '0;
      if (rise[i] && cnt_d[i] != 8'hFF) cnt_d[i] = cnt_d[i] + 8'd1;
    end
  end

  // Counter storage.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end
`endif

  // Combinational read mux; zero outside the window.
  always_comb begin
    rdata_o = '0;
    if (hit_o) begin
      case (off)
        8'd0:    rdata_o[0]           = gie_q;
        8'd1:    rdata_o[NUM_SRC-1:0] = mask_q;
        8'd2:    rdata_o[NUM_SRC-1:0] = pend_q;
        8'd3:    rdata_o              = {busy, 4'b0000, id_q};
        default: ;
      endcase
      for (int i = 0; i < NUM_SRC; i++)
        if (off == 8'(4 + i)) rdata_o = vec_q[i];
`ifdef INTC_EVT_CNT_EN
      for (int i = 0; i < NUM_SRC; i++)
        if (off == 8'(4 + NUM_SRC + i)) rdata_o = cnt_q[i];
`endif
    end
  end

endmodule
